// File: rtl/alu_result_select_pipe.sv
// Registered ALU result selector: picks one functional-unit result by opcode, tags it with
// zero/negative/illegal flags, and hands it to writeback through a 2-entry skid buffer.
module alu_result_select_pipe #(
  parameter int WIDTH       = 32,
  parameter int N_IN        = 12,
  parameter int SEL_W       = 4,
  parameter int TOP_ON_ONES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SEL_W-1:0]      opcode_i,
  input  logic [N_IN*WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_zero_o,
  output logic                  out_neg_o,
  output logic                  out_illegal_o,
  output logic [15:0]           illegal_count_o
);

  localparam int PW = WIDTH + 3;
  localparam logic [SEL_W-1:0] ALL_ONES = '1;
  localparam logic [PW-1:0] RESET_PAYLOAD = {{WIDTH{1'b0}}, 3'b100};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   main_q, skid_q, newPayload;
  logic            inReady_q;
  logic [15:0]     illegalCount_q;
  logic [WIDTH-1:0] selData;
  logic            selLegal;
  logic            accept, loadNew, loadSkid, promoteSkid;

  // With the legacy encoding the last input answers to the all-ones code instead of N_IN-1;
  // any code that matches no input falls through to a zero result marked illegal.
  always_comb begin
    selData  = '0;
    selLegal = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (opcode_i == ((TOP_ON_ONES != 0 && i == N_IN - 1) ? ALL_ONES : SEL_W'(i))) begin
        selData  = in_data_i[i*WIDTH +: WIDTH];
        selLegal = 1'b1;
      end
    end
    newPayload = {selData, (selData == '0), selData[WIDTH-1], ~selLegal};
  end

  assign accept = in_valid_i & inReady_q;

  always_comb begin
    state_d     = state_q;
    loadNew     = 1'b0;
    loadSkid    = 1'b0;
    promoteSkid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          loadNew = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready_i) begin
          loadNew = 1'b1;
        end else if (accept) begin
          state_d  = TWO;
          loadSkid = 1'b1;
        end else if (out_ready_i) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready_i) begin
          state_d     = ONE;
          promoteSkid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never combinationally follows out_ready.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= EMPTY;
      inReady_q      <= 1'b1;
      main_q         <= RESET_PAYLOAD;
      skid_q         <= RESET_PAYLOAD;
      illegalCount_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != TWO);
      if (loadNew) begin
        main_q <= newPayload;
      end else if (promoteSkid) begin
        main_q <= skid_q;
      end
      if (loadSkid) begin
        skid_q <= newPayload;
      end
      if (accept && !selLegal && illegalCount_q != 16'hFFFF) begin
        illegalCount_q <= illegalCount_q + 16'd1;
      end
    end
  end

  assign in_ready_o      = inReady_q;
  assign out_valid_o     = (state_q != EMPTY);
  assign out_data_o      = main_q[PW-1 -: WIDTH];
  assign out_zero_o      = main_q[2];
  assign out_neg_o       = main_q[1];
  assign out_illegal_o   = main_q[0];
  assign illegal_count_o = illegalCount_q;

endmodule
